// File: rtl/uberclock_pkg.sv
// Shared configuration field codes and lane advance modes for the uberclock NCO path.
// Used by the CSR wrapper and the phase accumulator bank.
package uberclock_pkg;

  localparam logic [1:0] CFG_INC  = 2'd0;
  localparam logic [1:0] CFG_OFF  = 2'd1;
  localparam logic [1:0] CFG_MODE = 2'd2;

  localparam logic [1:0] MODE_FREE  = 2'd0;
  localparam logic [1:0] MODE_GATED = 2'd1;
  localparam logic [1:0] MODE_HALT  = 2'd2;

  // Mode 3 is reserved and behaves like HALT.
  function automatic logic lane_advances(input logic [1:0] mode, input logic ce);
    case (mode)
      MODE_FREE:  return 1'b1;
      MODE_GATED: return ce;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/nco_phase_lane.sv
// One NCO phase lane: shadow/active config, accumulator, offset adder and
// registered phase/advance/wrap outputs.
module nco_phase_lane
  import uberclock_pkg::*;
#(
  parameter int PW = 19
) (
  input  logic          sys_clk,
  input  logic          rst,
  input  logic          ce_in,
  input  logic          wr_inc,
  input  logic          wr_off,
  input  logic          wr_mode,
  input  logic [PW-1:0] cfg_data,
  input  logic          commit,
  input  logic          clear,
  output logic [PW-1:0] phase_out,
  output logic          adv,
  output logic          wrap
);

  logic [PW-1:0] sh_inc_q, sh_inc_d, sh_off_q, sh_off_d;
  logic [1:0]    sh_mode_q, sh_mode_d;
  logic [PW-1:0] act_inc_q, act_inc_d, act_off_q, act_off_d;
  logic [1:0]    act_mode_q, act_mode_d;
  logic [PW-1:0] acc_q, acc_d;
  logic          adv_s_q, adv_s_d, wrap_s_q, wrap_s_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          adv_q, adv_d, wrap_q, wrap_d;
  logic [PW:0]   sum_full;

  always_comb begin
    // NOTE: every signal gets a default up front so no path leaves it unassigned (no latch).
    sh_inc_d   = sh_inc_q;
    sh_off_d   = sh_off_q;
    sh_mode_d  = sh_mode_q;
    act_inc_d  = act_inc_q;
    act_off_d  = act_off_q;
    act_mode_d = act_mode_q;
    acc_d      = acc_q;
    adv_s_d    = 1'b0;
    wrap_s_d   = 1'b0;

    if (wr_inc)  sh_inc_d  = cfg_data;
    if (wr_off)  sh_off_d  = cfg_data;
    if (wr_mode) sh_mode_d = cfg_data[1:0];

    // Commit copies the pre-write shadow; a same-cycle write lands in shadow only.
    if (commit) begin
      act_inc_d  = sh_inc_q;
      act_off_d  = sh_off_q;
      act_mode_d = sh_mode_q;
    end

    sum_full = {1'b0, acc_q} + {1'b0, act_inc_q};
    if (clear) begin
      acc_d = '0;
    end else if (lane_advances(act_mode_q, ce_in)) begin
      acc_d    = sum_full[PW-1:0];
      adv_s_d  = 1'b1;
      wrap_s_d = sum_full[PW];
    end

    // Output stage sees the accumulator and offset as they stand after the previous edge.
    phase_d = acc_q + act_off_q;
    adv_d   = adv_s_q;
    wrap_d  = wrap_s_q;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sh_inc_q   <= '0;
      sh_off_q   <= '0;
      sh_mode_q  <= MODE_FREE;
      act_inc_q  <= '0;
      act_off_q  <= '0;
      act_mode_q <= MODE_FREE;
      acc_q      <= '0;
      adv_s_q    <= 1'b0;
      wrap_s_q   <= 1'b0;
      phase_q    <= '0;
      adv_q      <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      sh_inc_q   <= sh_inc_d;
      sh_off_q   <= sh_off_d;
      sh_mode_q  <= sh_mode_d;
      act_inc_q  <= act_inc_d;
      act_off_q  <= act_off_d;
      act_mode_q <= act_mode_d;
      acc_q      <= acc_d;
      adv_s_q    <= adv_s_d;
      wrap_s_q   <= wrap_s_d;
      phase_q    <= phase_d;
      adv_q      <= adv_d;
      wrap_q     <= wrap_d;
    end
  end

  assign phase_out = phase_q;
  assign adv       = adv_q;
  assign wrap      = wrap_q;

endmodule

// File: rtl/nco_phase_bank.sv
// Bank of NCH phase accumulator lanes feeding the CORDIC NCOs: config address
// decode, the shared pending flag and output packing.
module nco_phase_bank
  import uberclock_pkg::*;
#(
  parameter int NCH = 4,
  parameter int PW  = 19,
  parameter int AW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              ce_in,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [1:0]        cfg_field,
  input  logic [PW-1:0]     cfg_data,
  input  logic              commit,
  input  logic [NCH-1:0]    clear,
  output logic [NCH*PW-1:0] phase_out,
  output logic [NCH-1:0]    adv,
  output logic [NCH-1:0]    wrap,
  output logic              pending
);

  logic write_ok;
  logic pending_q, pending_d;

  always_comb begin
    write_ok = cfg_we && (int'(cfg_addr) < NCH) &&
               (cfg_field == CFG_INC || cfg_field == CFG_OFF || cfg_field == CFG_MODE);
    // A write in the commit cycle is not covered by that commit, so it wins.
    if (write_ok)    pending_d = 1'b1;
    else if (commit) pending_d = 1'b0;
    else             pending_d = pending_q;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) pending_q <= 1'b0;
    else     pending_q <= pending_d;
  end

  assign pending = pending_q;

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    logic lane_sel;
    assign lane_sel = cfg_we && (cfg_addr == AW'(i));

    nco_phase_lane #(.PW(PW)) u_lane (
      .sys_clk   (sys_clk),
      .rst       (rst),
      .ce_in     (ce_in),
      .wr_inc    (lane_sel && (cfg_field == CFG_INC)),
      .wr_off    (lane_sel && (cfg_field == CFG_OFF)),
      .wr_mode   (lane_sel && (cfg_field == CFG_MODE)),
      .cfg_data  (cfg_data),
      .commit    (commit),
      .clear     (clear[i]),
      .phase_out (phase_out[i*PW +: PW]),
      .adv       (adv[i]),
      .wrap      (wrap[i])
    );
  end

endmodule

// File: tb/tb_nco_phase_bank.sv
// Randomized + directed bench for nco_phase_bank with a scoreboard fed by a
// lane-level arithmetic model and drained by an independent monitor.
module tb_nco_phase_bank;

  localparam int NCH = 4;
  localparam int PW  = 19;
  localparam int AW  = 2;
  localparam int MOD = 1 << PW;

  logic              sys_clk = 1'b0;
  logic              rst = 1'b1;
  logic              ce_in = 1'b0;
  logic              cfg_we = 1'b0;
  logic [AW-1:0]     cfg_addr = '0;
  logic [1:0]        cfg_field = '0;
  logic [PW-1:0]     cfg_data = '0;
  logic              commit = 1'b0;
  logic [NCH-1:0]    clear = '0;
  logic [NCH*PW-1:0] phase_out;
  logic [NCH-1:0]    adv, wrap;
  logic              pending;

  nco_phase_bank #(.NCH(NCH), .PW(PW)) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .ce_in     (ce_in),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_field (cfg_field),
    .cfg_data  (cfg_data),
    .commit    (commit),
    .clear     (clear),
    .phase_out (phase_out),
    .adv       (adv),
    .wrap      (wrap),
    .pending   (pending)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Behavioural lane model: plain integers, modular arithmetic.
  int m_sh_inc[NCH], m_sh_off[NCH], m_sh_mode[NCH];
  int m_inc[NCH], m_off[NCH], m_mode[NCH], m_acc[NCH];
  bit m_pend;

  typedef struct packed {
    int                tgt;
    logic [NCH*PW-1:0] ph;
    logic [NCH-1:0]    adv;
    logic [NCH-1:0]    wrap;
  } out_exp_t;

  typedef struct packed {
    int   tgt;
    logic pend;
  } pend_exp_t;

  out_exp_t  out_q[$];
  pend_exp_t pend_q[$];
  bit        mon_en = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_sh_inc[i] = 0; m_sh_off[i] = 0; m_sh_mode[i] = 0;
      m_inc[i] = 0; m_off[i] = 0; m_mode[i] = 0; m_acc[i] = 0;
    end
    m_pend = 1'b0;
  endtask

  // Drive one cycle's inputs and predict: pending after the coming edge,
  // phase/adv/wrap one edge after that.
  task automatic apply(input bit ce, input bit we, input int addr, input int field,
                       input int data, input bit cm, input logic [NCH-1:0] clr);
    out_exp_t  e;
    pend_exp_t p;
    bit        moves;
    bit        wr_ok;
    ce_in     = ce;
    cfg_we    = we;
    cfg_addr  = addr[AW-1:0];
    cfg_field = field[1:0];
    cfg_data  = data[PW-1:0];
    commit    = cm;
    clear     = clr;

    e.tgt = cyc + 2; e.ph = '0; e.adv = '0; e.wrap = '0;
    for (int i = 0; i < NCH; i++) begin
      moves = (m_mode[i] == 0) || (m_mode[i] == 1 && ce);
      if (clr[i]) begin
        m_acc[i] = 0;
      end else if (moves) begin
        e.adv[i]  = 1'b1;
        e.wrap[i] = (m_acc[i] + m_inc[i]) >= MOD;
        m_acc[i]  = (m_acc[i] + m_inc[i]) % MOD;
      end
    end
    if (cm) begin
      for (int i = 0; i < NCH; i++) begin
        m_inc[i] = m_sh_inc[i]; m_off[i] = m_sh_off[i]; m_mode[i] = m_sh_mode[i];
      end
    end
    wr_ok = we && (addr < NCH) && (field < 3);
    if (wr_ok) begin
      case (field)
        0:       m_sh_inc[addr]  = data % MOD;
        1:       m_sh_off[addr]  = data % MOD;
        default: m_sh_mode[addr] = data % 4;
      endcase
    end
    if (wr_ok)   m_pend = 1'b1;
    else if (cm) m_pend = 1'b0;
    for (int i = 0; i < NCH; i++) e.ph[i*PW +: PW] = PW'((m_acc[i] + m_off[i]) % MOD);
    p.tgt  = cyc + 1;
    p.pend = m_pend;
    out_q.push_back(e);
    pend_q.push_back(p);
  endtask

  task automatic drive(input bit ce, input bit we, input int addr, input int field,
                       input int data, input bit cm, input logic [NCH-1:0] clr);
    @(negedge sys_clk);
    apply(ce, we, addr, field, data, cm, clr);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 0, 0, 0, 1'b0, '0);
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < NCH; i++)
      check($sformatf("%s phase[%0d]", tag, i), 32'(phase_out[i*PW +: PW]), 32'd0);
    check({tag, " adv"}, 32'(adv), 32'd0);
    check({tag, " wrap"}, 32'(wrap), 32'd0);
    check({tag, " pending"}, 32'(pending), 32'd0);
  endtask

  task automatic reset_release();
    out_exp_t e;
    @(negedge sys_clk);
    rst = 1'b0;
    model_reset();
    e.tgt = cyc + 1; e.ph = '0; e.adv = '0; e.wrap = '0;
    out_q.push_back(e);
    mon_en = 1'b1;
    apply(1'b0, 1'b0, 0, 0, 0, 1'b0, '0);
  endtask

  task automatic async_reset();
    @(negedge sys_clk);
    #2;
    rst    = 1'b1;
    mon_en = 1'b0;
    out_q.delete();
    pend_q.delete();
    #1;
    check_zero("rst_async");
    repeat (3) begin
      @(negedge sys_clk);
      check_zero("rst_hold");
    end
    reset_release();
  endtask

  task automatic random_run(input int n);
    repeat (n) begin
      drive(1'b1 & $urandom_range(0, 1), ($urandom % 3) == 0, $urandom_range(0, NCH - 1),
            $urandom_range(0, 3), $urandom_range(0, MOD - 1), ($urandom % 6) == 0,
            (($urandom % 10) == 0) ? NCH'($urandom) : '0);
    end
  endtask

  // Monitor: outputs are presented every cycle, compared #1 after the edge.
  always @(posedge sys_clk) begin
    out_exp_t  e;
    pend_exp_t p;
    #1;
    if (mon_en) begin
      while (pend_q.size() > 0 && pend_q[0].tgt <= cyc) begin
        p = pend_q.pop_front();
        check("pending", 32'(pending), 32'(p.pend));
      end
      while (out_q.size() > 0 && out_q[0].tgt <= cyc) begin
        e = out_q.pop_front();
        for (int i = 0; i < NCH; i++)
          check($sformatf("phase[%0d]", i), 32'(phase_out[i*PW +: PW]), 32'(e.ph[i*PW +: PW]));
        check("adv", 32'(adv), 32'(e.adv));
        check("wrap", 32'(wrap), 32'(e.wrap));
      end
    end
  end

  initial begin
    #12;
    check_zero("por");
    reset_release();
    idle(20);

    // Lane 0 FREE, inc 52429: wraps on the 10th step to acc = 2.
    drive(1'b0, 1'b1, 0, 0, 52429, 1'b0, '0);
    drive(1'b0, 1'b0, 0, 0, 0, 1'b1, '0);
    idle(14);

    // Lane 1 GATED inc 1000, ce every 10th cycle.
    drive(1'b0, 1'b1, 1, 2, 1, 1'b0, '0);
    drive(1'b0, 1'b1, 1, 0, 1000, 1'b0, '0);
    drive(1'b0, 1'b0, 0, 0, 0, 1'b1, '0);
    for (int k = 0; k < 30; k++) drive(k % 10 == 9, 1'b0, 0, 0, 0, 1'b0, '0);

    // Separate writes to lanes 0 and 2, one commit; then write+commit together.
    drive(1'b0, 1'b1, 0, 0, 7, 1'b0, '0);
    idle(2);
    drive(1'b0, 1'b1, 2, 0, 300, 1'b0, '0);
    idle(2);
    drive(1'b0, 1'b0, 0, 0, 0, 1'b1, '0);
    idle(3);
    drive(1'b0, 1'b1, 0, 0, 11, 1'b1, '0);
    idle(3);
    drive(1'b0, 1'b0, 0, 0, 0, 1'b1, '0);
    idle(2);

    // Lane 3 offset 0x40000 with inc 0; clear with ce on GATED lane 1.
    drive(1'b0, 1'b1, 3, 1, 32'h40000, 1'b0, '0);
    drive(1'b0, 1'b0, 0, 0, 0, 1'b1, '0);
    idle(3);
    drive(1'b1, 1'b0, 0, 0, 0, 1'b0, 4'b0010);
    idle(3);

    random_run(300);
    async_reset();
    idle(5);
    random_run(100);
    idle(4);
    repeat (3) @(posedge sys_clk);
    #2;
    check("scoreboard drained", 32'(out_q.size() + pend_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
